// File: rtl/pwm_duty_ramp.sv
// Config buffer and soft-start duty slew feeding the PWM generator; updates land only on period ticks.
// Optional build macro PWM_RAMP_TICKCNT_EN adds the ramp_ticks counter output.
`timescale 1ns/1ps
module pwm_duty_ramp #(
  parameter int          WIDTH      = 16,
  parameter int unsigned PERIOD_RST = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_target,
  input  logic [WIDTH-1:0] cfg_step,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             busy,
  output logic             done
`ifdef PWM_RAMP_TICKCNT_EN
  ,
  output logic [WIDTH-1:0] ramp_ticks
`endif
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             done_q, done_d;

  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_period_q, pend_target_q, pend_step_q;

  logic             accept, apply;
  logic [WIDTH-1:0] eff_period, eff_target, eff_step;
  logic [WIDTH-1:0] base, diff, up_val, ramp_val;
  logic [WIDTH:0]   up_sum;

  function automatic state_t classify(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] t);
    if (d < t)      return RAMP_UP;
    else if (d > t) return RAMP_DOWN;
    else            return HOLD;
  endfunction

  assign cfg_ready  = !pend_valid_q;
  assign accept     = cfg_valid && cfg_ready;
  // With enable low the pending config is taken at once; otherwise only on a tick.
  assign apply      = pend_valid_q && (!enable || tick);

  assign eff_period = apply ? pend_period_q : period_q;
  assign eff_target = apply ? ((pend_target_q > pend_period_q) ? pend_period_q : pend_target_q)
                            : target_q;
  assign eff_step   = apply ? pend_step_q : step_q;

  assign base   = (duty_q > eff_period) ? eff_period : duty_q;
  assign diff   = (eff_target >= base) ? (eff_target - base) : (base - eff_target);
  assign up_sum = {1'b0, base} + {1'b0, eff_step};
  assign up_val = up_sum[WIDTH] ? '1 : up_sum[WIDTH-1:0];

  always_comb begin
    if (eff_step == '0 || diff <= eff_step) ramp_val = eff_target;
    else if (eff_target > base)             ramp_val = up_val;
    else                                    ramp_val = base - eff_step;
  end

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d      = state_q;
    period_d     = period_q;
    duty_d       = duty_q;
    target_d     = target_q;
    step_d       = step_q;
    done_d       = 1'b0;
    pend_valid_d = pend_valid_q;

    if (accept)     pend_valid_d = 1'b1;
    else if (apply) pend_valid_d = 1'b0;

    if (!enable) begin
      duty_d  = '0;
      state_d = IDLE;
      if (apply) begin
        period_d = eff_period;
        target_d = eff_target;
        step_d   = eff_step;
      end
    end else if (tick) begin
      period_d = eff_period;
      target_d = eff_target;
      step_d   = eff_step;
      duty_d   = ramp_val;
      state_d  = classify(ramp_val, eff_target);
      done_d   = (state_q == RAMP_UP || state_q == RAMP_DOWN) && (ramp_val == eff_target);
    end else if (state_q == IDLE) begin
      state_d = classify(duty_q, target_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_q     <= WIDTH'(PERIOD_RST);
      duty_q       <= '0;
      target_q     <= '0;
      step_q       <= '0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      step_q       <= step_d;
      done_q       <= done_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // NOTE: pending payload needs no reset; pend_valid_q alone marks it meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_period_q <= cfg_period;
      pend_target_q <= cfg_target;
      pend_step_q   <= cfg_step;
    end
  end

  assign period_out = period_q;
  assign duty_out   = duty_q;
  assign busy       = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign done       = done_q;

`ifdef PWM_RAMP_TICKCNT_EN
  // Counts ticks that actually moved duty; an applying tick restarts the count at itself.
  logic [WIDTH-1:0] cnt_q, cnt_base;
  logic             ramp_tick;

  assign ramp_tick = enable && tick && (base != eff_target);
  assign cnt_base  = apply ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= '0;
    else if (ramp_tick && cnt_base != '1) cnt_q <= cnt_base + 1'b1;
    else                                  cnt_q <= cnt_base;
  end

  assign ramp_ticks = cnt_q;
`else
  // Tick counter not built.
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: ramps, clamps, handshake timing, wrap guard, enable drop, reset.
`timescale 1ns/1ps
module tb_pwm_duty_ramp;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst, enable, tick, cfg_valid, cfg_ready, busy, done;
  logic [WIDTH-1:0] cfg_period, cfg_target, cfg_step, period_out, duty_out;
`ifdef PWM_RAMP_TICKCNT_EN
  logic [WIDTH-1:0] ramp_ticks;
`endif

  int checks = 0;
  int errors = 0;

  pwm_duty_ramp #(.WIDTH(WIDTH), .PERIOD_RST(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tick       (tick),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .period_out (period_out),
    .duty_out   (duty_out),
    .busy       (busy),
    .done       (done)
`ifdef PWM_RAMP_TICKCNT_EN
    ,
    .ramp_ticks (ramp_ticks)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic send_cfg(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] s);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_target = t;
    cfg_step   = s;
    cyc();
    cfg_valid  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_duty"},   32'(duty_out),   32'd0);
    check({tag, "_period"}, 32'(period_out), 32'd100);
    check({tag, "_busy"},   32'(busy),       32'd0);
    check({tag, "_done"},   32'(done),       32'd0);
    check({tag, "_ready"},  32'(cfg_ready),  32'd1);
`ifdef PWM_RAMP_TICKCNT_EN
    check({tag, "_rticks"}, 32'(ramp_ticks), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_target = '0; cfg_step = '0;
    cyc(); cyc();
    check_reset_state("reset");
    rst = 1'b0;

    // Soft start 0 -> 50 in steps of 10.
    send_cfg(16'd100, 16'd50, 16'd10);
    check("s1_ready_low", 32'(cfg_ready), 32'd0);
    enable = 1'b1;
    cyc();
    check("s1_hold_before_tick", 32'(busy), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      check($sformatf("s1_duty_%0d", i), 32'(duty_out), 32'(10 * i));
      check($sformatf("s1_busy_%0d", i), 32'(busy), (i < 5) ? 32'd1 : 32'd0);
      check($sformatf("s1_done_%0d", i), 32'(done), (i == 5) ? 32'd1 : 32'd0);
    end
    check("s1_period", 32'(period_out), 32'd100);
    check("s1_ready_back", 32'(cfg_ready), 32'd1);
    cyc();
    check("s1_done_one_cycle", 32'(done), 32'd0);
`ifdef PWM_RAMP_TICKCNT_EN
    check("s1_rticks", 32'(ramp_ticks), 32'd5);
`endif
    do_tick();
    check("s1_hold_duty", 32'(duty_out), 32'd50);
    check("s1_hold_no_done", 32'(done), 32'd0);
`ifdef PWM_RAMP_TICKCNT_EN
    check("s1_rticks_held", 32'(ramp_ticks), 32'd5);
`endif

    // Ramp down 50 -> 5 with step 20: 30, 10, 5.
    send_cfg(16'd100, 16'd5, 16'd20);
    do_tick();
    check("s2_duty_30", 32'(duty_out), 32'd30);
    check("s2_busy", 32'(busy), 32'd1);
    do_tick();
    check("s2_duty_10", 32'(duty_out), 32'd10);
    check("s2_no_done", 32'(done), 32'd0);
    do_tick();
    check("s2_duty_5", 32'(duty_out), 32'd5);
    check("s2_done", 32'(done), 32'd1);
    check("s2_hold", 32'(busy), 32'd0);

    // Target above period clamps; shrinking period clamps current duty.
    send_cfg(16'd100, 16'd200, 16'd0);
    do_tick();
    check("s3_clamp_target", 32'(duty_out), 32'd100);
    send_cfg(16'd100, 16'd80, 16'd0);
    do_tick();
    check("s3_duty_80", 32'(duty_out), 32'd80);
    send_cfg(16'd50, 16'd70, 16'd5);
    do_tick();
    check("s3_clamp_period", 32'(duty_out), 32'd50);
    check("s3_period_50", 32'(period_out), 32'd50);

    // Back-to-back configs: second is held off until the first applies.
    cfg_valid = 1'b1; cfg_period = 16'd100; cfg_target = 16'd60; cfg_step = 16'd5;
    check("s4_ready_a", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_target = 16'd20; cfg_step = 16'd0;
    check("s4_ready_held", 32'(cfg_ready), 32'd0);
    cyc();
    check("s4_ready_still_held", 32'(cfg_ready), 32'd0);
    do_tick();
    check("s4_apply_a", 32'(duty_out), 32'd55);
    check("s4_period_a", 32'(period_out), 32'd100);
    check("s4_ready_after_apply", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0;
    check("s4_b_accepted", 32'(cfg_ready), 32'd0);
    do_tick();
    check("s4_apply_b", 32'(duty_out), 32'd20);
    check("s4_done_b", 32'(done), 32'd1);

    // Config accepted on a tick cycle waits for the following tick.
    cfg_valid = 1'b1; cfg_period = 16'd100; cfg_target = 16'd40; cfg_step = 16'd10;
    tick = 1'b1;
    cyc();
    tick = 1'b0; cfg_valid = 1'b0;
    check("s4_same_tick_duty", 32'(duty_out), 32'd20);
    check("s4_same_tick_pending", 32'(cfg_ready), 32'd0);
    do_tick();
    check("s4_next_tick_apply", 32'(duty_out), 32'd30);

    // Top-of-range ramp must not wrap.
    send_cfg(16'hFFFF, 16'hFFF0, 16'd0);
    do_tick();
    check("s5_duty_fff0", 32'(duty_out), 32'h0000FFF0);
    send_cfg(16'hFFFF, 16'hFFFF, 16'h0020);
    do_tick();
    check("s5_no_wrap", 32'(duty_out), 32'h0000FFFF);

    // Drop enable mid-ramp: duty to 0 and ticks ignored.
    send_cfg(16'hFFFF, 16'd0, 16'd1);
    do_tick();
    check("s5_ramp_down", 32'(duty_out), 32'h0000FFFE);
    check("s5_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    cyc();
    check("s5_disable_duty", 32'(duty_out), 32'd0);
    check("s5_disable_busy", 32'(busy), 32'd0);
    do_tick();
    check("s5_tick_ignored", 32'(duty_out), 32'd0);
    check("s5_tick_ignored_period", 32'(period_out), 32'h0000FFFF);

    // While disabled, a pending config applies without a tick.
    send_cfg(16'd200, 16'd100, 16'd10);
    cyc();
    check("s6_idle_apply_period", 32'(period_out), 32'd200);
    check("s6_idle_apply_duty", 32'(duty_out), 32'd0);
    check("s6_idle_apply_ready", 32'(cfg_ready), 32'd1);
`ifdef PWM_RAMP_TICKCNT_EN
    check("s6_rticks_cleared", 32'(ramp_ticks), 32'd0);
`endif

    // Reset mid-ramp with a pending config.
    enable = 1'b1;
    cyc();
    do_tick();
    check("s7_ramp_start", 32'(duty_out), 32'd10);
    check("s7_busy", 32'(busy), 32'd1);
    send_cfg(16'd300, 16'd50, 16'd5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("s7_rst");
    do_tick();
    check("s7_pending_dropped_duty", 32'(duty_out), 32'd0);
    check("s7_pending_dropped_period", 32'(period_out), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
